// File: rtl/bsg_fifo_credit_receiver.sv
// Receive end of a credit-based link: buffers sender words in a circular FIFO
// and returns credits to the sender, coalesced up to max_step_p per cycle.
module bsg_fifo_credit_receiver #(
    parameter int width_p        = 8,
    parameter int els_p          = 4,
    parameter int max_step_p     = 2,
    parameter int flush_cycles_p = 3
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             v_i,
    input  logic [width_p-1:0]               data_i,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    input  logic                             yumi_i,
    output logic [$clog2(max_step_p+1)-1:0]  credit_o,
    output logic                             overflow_o
);
    localparam int PTR_W  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W  = $clog2(els_p + 1);
    localparam int CRED_W = $clog2(max_step_p + 1);
    localparam int TMR_W  = (flush_cycles_p > 0) ? $clog2(flush_cycles_p + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(els_p - 1);

    logic [width_p-1:0] r_mem [els_p];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_pending;
    logic [TMR_W-1:0]   r_timer;
    logic [CRED_W-1:0]  r_credit;

    logic               w_full;
    logic               w_deq;
    logic               w_enq;
    logic [CNT_W-1:0]   w_sum;
    logic               w_full_ret;
    logic               w_flush_ret;
    logic [CRED_W-1:0]  w_credit_n;
    logic [CNT_W-1:0]   w_pending_n;
    logic [TMR_W-1:0]   w_timer_n;

    assign w_full = (r_count == CNT_W'(els_p));
    assign w_deq  = yumi_i & (r_count != '0);
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign w_enq  = v_i & (~w_full | w_deq);

    assign v_o        = (r_count != '0);
    assign data_o     = r_mem[r_rd_ptr];
    assign credit_o   = r_credit;
    assign overflow_o = r_overflow;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            if (v_i & ~w_enq) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Credits are batched until max_step_p accumulate or the batch sits idle too long.
    assign w_sum       = r_pending + CNT_W'(w_deq);
    assign w_full_ret  = (w_sum >= CNT_W'(max_step_p));
    assign w_flush_ret = (w_sum != '0) && (r_timer == TMR_W'(flush_cycles_p));

    always_comb begin
        w_credit_n = '0;
        if (w_full_ret) begin
            w_credit_n = CRED_W'(max_step_p);
        end else if (w_flush_ret) begin
            w_credit_n = CRED_W'(w_sum);
        end
        w_pending_n = w_sum - CNT_W'(w_credit_n);
        w_timer_n   = r_timer + TMR_W'(1);
        if ((w_credit_n != '0) || (w_sum == '0)) begin
            w_timer_n = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pending <= '0;
            r_timer   <= '0;
            r_credit  <= '0;
        end else begin
            r_pending <= w_pending_n;
            r_timer   <= w_timer_n;
            r_credit  <= w_credit_n;
        end
    end
endmodule

// File: tb/tb_bsg_fifo_credit_receiver.sv
// Directed and randomized bench for bsg_fifo_credit_receiver against a
// queue-based receiver model and a sender credit-counter model.
module tb_bsg_fifo_credit_receiver;
    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       v_i;
    logic [7:0] data_i;
    logic       v_o;
    logic [7:0] data_o;
    logic       yumi_i;
    logic [1:0] credit_o;
    logic       overflow_o;

    bsg_fifo_credit_receiver #(
        .width_p(8), .els_p(4), .max_step_p(2), .flush_cycles_p(3)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .credit_o(credit_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int total  = 0;
    int passed = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         movf;
    int         owed;      // credits earned but not yet returned
    int         idle;      // cycles the current partial batch has waited
    int         mcred;     // credit value visible this cycle
    int         scnt;      // sender's credit counter
    int         tot_deq, tot_cred;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        movf = 0; owed = 0; idle = 0; mcred = 0; scnt = 4;
        tot_deq = 0; tot_cred = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".v_o"}, 32'(v_o), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".data_o"}, 32'(data_o), 32'(mq[0]));
        chk({tag, ".credit_o"}, 32'(credit_o), 32'(mcred));
        chk({tag, ".overflow_o"}, 32'(overflow_o), 32'(movf));
    endtask

    // Drive one cycle from a negedge, advance the model, check at the next negedge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] d, input logic y);
        bit deq;
        int batch;
        v_i = v; data_i = d; yumi_i = y;
        deq   = y && (mq.size() != 0);
        batch = owed + (deq ? 1 : 0);
        scnt  = scnt - (v ? 1 : 0) + mcred;
        tot_cred += mcred;
        if (deq) begin
            void'(mq.pop_front());
            tot_deq++;
        end
        if (v) begin
            if (mq.size() < 4) mq.push_back(d);
            else movf = 1;
        end
        if (batch >= 2) begin
            mcred = 2; owed = batch - 2; idle = 0;
        end else if (batch != 0 && idle == 3) begin
            mcred = batch; owed = 0; idle = 0;
        end else begin
            mcred = 0; owed = batch; idle = (batch == 0) ? 0 : idle + 1;
        end
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    initial begin
        reset_n_i = 1'b0; v_i = 0; data_i = '0; yumi_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        chk("rst.v_o", 32'(v_o), 0);
        chk("rst.credit_o", 32'(credit_o), 0);
        chk("rst.overflow_o", 32'(overflow_o), 0);
        reset_n_i = 1'b1;

        // Fill with A1..A4, no consumer
        for (int i = 0; i < 4; i++) cycle("fill", 1, 8'hA1 + 8'(i), 0);
        cycle("hold", 0, 8'h00, 0);

        // Drain four in a row: credits of 2 at t+2 and t+4
        for (int i = 0; i < 4; i++) cycle("drain", 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) cycle("drain_tail", 0, 8'h00, 0);

        // Single yumi then idle: one flushed credit four cycles later
        cycle("single_push", 1, 8'h5C, 0);
        cycle("single_yumi", 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) cycle("flush", 0, 8'h00, 0);
        chk("flush.conserve", 32'(tot_cred), 32'(tot_deq));

        // Overflow: full without deq drops, full with deq accepts
        for (int i = 0; i < 4; i++) cycle("ovf_fill", 1, 8'h30 + 8'(i), 0);
        cycle("ovf_drop", 1, 8'hEE, 0);
        cycle("ovf_sticky", 0, 8'h00, 0);
        cycle("full_swap", 1, 8'h77, 1);
        for (int i = 0; i < 5; i++) cycle("ovf_drain", 0, 8'h00, 1);

        // Reset in the middle of traffic
        cycle("pre_rst", 1, 8'h42, 0);
        v_i = 1; data_i = 8'h43; yumi_i = 1;
        #2 reset_n_i = 1'b0;
        #1;
        chk("midrst.v_o", 32'(v_o), 0);
        chk("midrst.credit_o", 32'(credit_o), 0);
        chk("midrst.overflow_o", 32'(overflow_o), 0);
        model_reset();
        @(negedge clk_i);
        v_i = 0; yumi_i = 0;
        reset_n_i = 1'b1;
        cycle("post_rst", 0, 8'h00, 0);
        cycle("post_rst", 0, 8'h00, 1);

        // Random traffic with a credit-respecting sender
        for (int i = 0; i < 400; i++) begin
            logic v, y;
            v = (scnt > 0) && ($urandom_range(0, 2) != 0);
            y = ($urandom_range(0, 3) != 0);
            cycle("rand", v, 8'($urandom), y);
            if (scnt < 0 || scnt > 4) chk("rand.sender_cnt", 32'(scnt), 32'(4));
        end
        for (int i = 0; i < 4; i++) cycle("rand_drain", 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) cycle("rand_idle", 0, 8'h00, 0);
        cycle("rand_final", 0, 8'h00, 0);
        chk("rand.sender_restored", 32'(scnt), 32'(4));
        chk("rand.conserve", 32'(tot_cred), 32'(tot_deq));
        chk("rand.no_ovf", 32'(overflow_o), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
